// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_pkg
// Description : Shared op encodings, FSM state encoding and special-case
//               constants for the RISC-V M-extension multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Special-case results, sliced down to XLEN by the user
  localparam int                    MAX_XLEN      = 64;
  localparam logic [MAX_XLEN-1:0]   DIVZ_QUOTIENT = '1;
  localparam logic [MAX_XLEN-1:0]   OVF_REMAINDER = '0;

  // Divide/remainder ops all have funct3[2] set
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Remainder ops are the upper pair of the divide group
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the iterative datapath: BITS_PER_CYCLE
//               chained shift-add multiply or restoring-divide steps on
//               unsigned magnitudes held in a {hi, lo} register pair.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  // Multiply: hi = partial product, lo = multiplier (shifted out LSB first).
  // Divide:   hi = partial remainder, lo = dividend/quotient (shifted left).
  logic [XLEN-1:0] hi_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] lo_c [BITS_PER_CYCLE+1];

  assign hi_c[0] = hi_in;
  assign lo_c[0] = lo_in;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          ge;

    // Shift-add: add multiplicand when the current multiplier bit is set
    assign sum     = {1'b0, hi_c[i]} + (lo_c[i][0] ? {1'b0, operand} : '0);
    // Restoring divide: the remainder is always < divisor, so the shifted
    // value fits XLEN+1 bits and a set MSB of diff means "does not go"
    assign shifted = {hi_c[i], lo_c[i][XLEN-1]};
    assign diff    = shifted - {1'b0, operand};
    assign ge      = ~diff[XLEN];

    assign hi_c[i+1] = is_div ? (ge ? diff[XLEN-1:0] : shifted[XLEN-1:0])
                              : sum[XLEN:1];
    assign lo_c[i+1] = is_div ? {lo_c[i][XLEN-2:0], ge}
                              : {sum[0], lo_c[i][XLEN-1:1]};
  end

  assign hi_out = hi_c[BITS_PER_CYCLE];
  assign lo_out = lo_c[BITS_PER_CYCLE];

endmodule
`default_nettype wire

// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Iterative RISC-V M-extension multiply/divide unit. Works on
//               operand magnitudes, applies sign correction in one FIX cycle,
//               and short-circuits divide-by-zero and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int              N        = XLEN / BITS_PER_CYCLE;
  localparam int              CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES     = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic [XLEN-1:0]   step_hi, step_lo;

  // Operand conditioning for the incoming request
  logic              a_neg, b_neg, divz, ovf, accept;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;

  assign a_neg = a_is_signed(funct3) & op_a[XLEN-1];
  assign b_neg = b_is_signed(funct3) & op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign divz  = is_div_op(funct3) && (op_b == '0);
  assign ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == MIN_VAL) && (op_b == ONES);

  // Bypass value: quotient all-ones / remainder = dividend on /0, MIN / 0 on overflow
  assign special_val = divz ? (is_rem_op(funct3) ? op_a : DIVZ_QUOTIENT[XLEN-1:0])
                            : (is_rem_op(funct3) ? OVF_REMAINDER[XLEN-1:0] : MIN_VAL);

  // Final sign correction and high/low selection
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_q ? -hi_q : hi_q;

  // Select the architectural result for the latched op
  always_comb begin
    fix_result = prod_fix[XLEN-1:0];
    case (f3_q)
      F3_MUL:                         fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   fix_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                fix_result = quo_fix;
      default:                        fix_result = rem_fix;
    endcase
  end

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div  (f3_q[2]),
    .hi_in   (hi_q),
    .lo_in   (lo_q),
    .operand (opnd_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  assign accept = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state and datapath update; flush overrides everything but reset
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      ST_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_result;
        rd_out_d = rd_q;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      f3_d  = funct3;
      rd_d  = rd_in;
      cnt_d = '0;
      if (divz || ovf) begin
        result_d = special_val;
        rd_out_d = rd_in;
        state_d  = ST_DONE;
      end else begin
        hi_d    = '0;
        lo_d    = is_div_op(funct3) ? a_mag : b_mag;
        opnd_d  = is_div_op(funct3) ? b_mag : a_mag;
        neg_d   = is_rem_op(funct3) ? a_neg : (a_neg ^ b_neg);
        state_d = ST_CALC;
      end
    end

    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed self-checking bench for riscv_muldiv_unit with one
//               radix-2 instance and one radix-16 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, busy4, done4;
  logic [31:0] result, result4;
  logic [4:0]  rd_out, rd_out4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  riscv_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_in(rd_in), .flush(flush), .busy(busy4), .done(done4),
    .result(result4), .rd_out(rd_out4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one clock; operands are scrambled afterwards
  task automatic issue(input bit sel4, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    funct3 = f; op_a = a; op_b = b; rd_in = rd;
    if (sel4) start4 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start4 = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_in = 5'd31;
  endtask

  // Cycles from the acceptance edge to the first done; -1 if it never comes
  task automatic wait_done(input bit sel4, output int lat);
    lat = 1;
    while (!((sel4 ? done4 : done) === 1'b1) && lat < 200) begin
      step();
      lat++;
    end
    if ((sel4 ? done4 : done) !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", result); end
    tests++; if (rd_out !== 5'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mul();
    int lat;
    issue(0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd13);
    wait_done(0, lat);
    tests++; if (lat !== 34) begin fails++; $display("FAIL mul_latency: got %0d want 34", lat); end
    tests++; if (result !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_result: got %h want ffffffeb", result); end
    tests++; if (rd_out !== 5'd13) begin fails++; $display("FAIL mul_rd: got %0d want 13", rd_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mul_busy_at_done: got %b want 0", busy); end
  endtask

  task automatic test_mul_high();
    int lat;
    issue(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    wait_done(0, lat);
    tests++; if (result !== 32'hFFFF_FFFE || lat !== 34) begin fails++; $display("FAIL mulhu: got %h lat %0d want fffffffe lat 34", result, lat); end
    issue(0, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    wait_done(0, lat);
    tests++; if (result !== 32'h0000_0000) begin fails++; $display("FAIL mulh: got %h want 00000000", result); end
    issue(0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    wait_done(0, lat);
    tests++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mulhsu: got %h want ffffffff", result); end
  endtask

  task automatic test_div();
    int lat;
    issue(0, DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_done(0, lat);
    tests++; if (result !== 32'hFFFF_FFFD || lat !== 34) begin fails++; $display("FAIL div: got %h lat %0d want fffffffd lat 34", result, lat); end
    issue(0, REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
    wait_done(0, lat);
    tests++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem: got %h want ffffffff", result); end
    issue(0, DIVU, 32'd100, 32'd7, 5'd6);
    wait_done(0, lat);
    tests++; if (result !== 32'd14) begin fails++; $display("FAIL divu: got %h want 0000000e", result); end
    issue(0, REMU, 32'd100, 32'd7, 5'd7);
    wait_done(0, lat);
    tests++; if (result !== 32'd2) begin fails++; $display("FAIL remu: got %h want 00000002", result); end
  endtask

  task automatic test_special();
    int lat;
    issue(0, REMU, 32'd5, 32'd0, 5'd8);
    wait_done(0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL remu_div0_latency: got %0d want 1", lat); end
    tests++; if (result !== 32'd5) begin fails++; $display("FAIL remu_div0: got %h want 00000005", result); end
    issue(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    wait_done(0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
    tests++; if (result !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf: got %h want 80000000", result); end
    issue(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    wait_done(0, lat);
    tests++; if (result !== 32'h0 || lat !== 1) begin fails++; $display("FAIL rem_ovf: got %h lat %0d want 00000000 lat 1", result, lat); end
    issue(0, DIVU, 32'd5, 32'd0, 5'd11);
    wait_done(0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL divu_div0_latency: got %0d want 1", lat); end
    tests++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_div0: got %h want ffffffff", result); end
    tests++; if (rd_out !== 5'd11) begin fails++; $display("FAIL divu_div0_rd: got %0d want 11", rd_out); end
  endtask

  // Runs right after test_special, so the held result is ffffffff / rd 11
  task automatic test_flush();
    int seen;
    issue(0, MUL, 32'd3, 32'd5, 5'd9);
    for (int i = 0; i < 9; i++) step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy_before: got %b want 1", busy); end
    flush = 1'b1; start = 1'b1; funct3 = DIVU; op_a = 32'd1; op_b = 32'd0;
    step();
    flush = 1'b0; start = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL flush_idle: got busy %b done %b want 0 0", busy, done); end
    tests++; if (result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL flush_result_hold: got %h want ffffffff", result); end
    tests++; if (rd_out !== 5'd11) begin fails++; $display("FAIL flush_rd_hold: got %0d want 11", rd_out); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_done: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(0, MUL, 32'd6, 32'd7, 5'd3);
    lat = 1;
    while (!(done === 1'b1) && lat < 200) begin
      if (lat == 5) begin
        funct3 = DIVU; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd4; start = 1'b1;
      end
      step();
      start = 1'b0;
      lat++;
    end
    tests++; if (lat !== 34) begin fails++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
    tests++; if (result !== 32'd42) begin fails++; $display("FAIL busy_start_result: got %h want 0000002a", result); end
    tests++; if (rd_out !== 5'd3) begin fails++; $display("FAIL busy_start_rd: got %0d want 3", rd_out); end
    issue(0, REMU, 32'd100, 32'd7, 5'd22);
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy %b done %b want 1 0", busy, done); end
    wait_done(0, lat);
    tests++; if (lat !== 34) begin fails++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    tests++; if (result !== 32'd2 || rd_out !== 5'd22) begin fails++; $display("FAIL b2b_result: got %h rd %0d want 00000002 rd 22", result, rd_out); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_single_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    issue(0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd13);
    for (int i = 0; i < 9; i++) step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got busy %b done %b want 0 0", busy, done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rstmid_result: got %h want 00000000", result); end
    tests++; if (rd_out !== 5'd0) begin fails++; $display("FAIL rstmid_rd: got %0d want 0", rd_out); end
    for (int i = 0; i < 40; i++) step();
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_stays_idle: got busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_radix16();
    int lat;
    issue(1, MUL, 32'd7, 32'hFFFF_FFFD, 5'd13);
    wait_done(1, lat);
    tests++; if (lat !== 10) begin fails++; $display("FAIL r16_latency: got %0d want 10", lat); end
    tests++; if (result4 !== 32'hFFFF_FFEB) begin fails++; $display("FAIL r16_result: got %h want ffffffeb", result4); end
    tests++; if (rd_out4 !== 5'd13) begin fails++; $display("FAIL r16_rd: got %0d want 13", rd_out4); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_radix16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
